// File: rtl/lcd_img_pkg.sv
// Shared command codes and controller state encoding for the LCD image-buffer controller.
package lcd_img_pkg;

    localparam logic [3:0] CMD_WRITE   = 4'd0;
    localparam logic [3:0] CMD_UP      = 4'd1;
    localparam logic [3:0] CMD_DOWN    = 4'd2;
    localparam logic [3:0] CMD_LEFT    = 4'd3;
    localparam logic [3:0] CMD_RIGHT   = 4'd4;
    localparam logic [3:0] CMD_MAX     = 4'd5;
    localparam logic [3:0] CMD_MIN     = 4'd6;
    localparam logic [3:0] CMD_AVG     = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW = 4'd8;
    localparam logic [3:0] CMD_ROT_CW  = 4'd9;
    localparam logic [3:0] CMD_MIR_X   = 4'd10;
    localparam logic [3:0] CMD_MIR_Y   = 4'd11;
    localparam logic [3:0] CMD_ORIGIN  = 4'd12;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CMD,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: produces the new window pixels and a write enable
// for max/min/average/rotate/mirror commands; all other commands leave the window alone.
module lcd_win_alu
    import lcd_img_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3,
    output logic          we
);

    logic [DW-1:0] max01, max23, max_all;
    logic [DW-1:0] min01, min23, min_all;
    logic [DW+1:0] sum;
    logic [DW-1:0] avg;

    assign max01   = (p0 > p1) ? p0 : p1;
    assign max23   = (p2 > p3) ? p2 : p3;
    assign max_all = (max01 > max23) ? max01 : max23;
    assign min01   = (p0 < p1) ? p0 : p1;
    assign min23   = (p2 < p3) ? p2 : p3;
    assign min_all = (min01 < min23) ? min01 : min23;

    // Two guard bits keep the four-pixel sum exact before the floor divide.
    assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    assign avg = sum[DW+1:2];

    always_comb begin
        q0 = p0;
        q1 = p1;
        q2 = p2;
        q3 = p3;
        we = 1'b0;
        case (cmd)
            CMD_MAX: begin
                q0 = max_all; q1 = max_all; q2 = max_all; q3 = max_all; we = 1'b1;
            end
            CMD_MIN: begin
                q0 = min_all; q1 = min_all; q2 = min_all; q3 = min_all; we = 1'b1;
            end
            CMD_AVG: begin
                q0 = avg; q1 = avg; q2 = avg; q3 = avg; we = 1'b1;
            end
            CMD_ROT_CCW: begin
                q0 = p1; q1 = p3; q2 = p0; q3 = p2; we = 1'b1;
            end
            CMD_ROT_CW: begin
                q0 = p2; q1 = p0; q2 = p3; q3 = p1; we = 1'b1;
            end
            CMD_MIR_X: begin
                q0 = p2; q1 = p3; q2 = p0; q3 = p1; we = 1'b1;
            end
            CMD_MIR_Y: begin
                q0 = p1; q1 = p0; q2 = p3; q3 = p2; we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_img_ctrl.sv
// Image-buffer controller: loads an image from IROM, applies host window commands around a
// movable origin and dumps the buffer to IRAM on request.
//   state    | meaning
//   ST_LOAD  | stream IROM into the buffer, plus one drain cycle for the last read
//   ST_CMD   | idle, busy=0, accept one command when cmd_valid
//   ST_EXEC  | apply the window op or origin move in a single cycle
//   ST_WRITE | stream buffer to IRAM, one pixel per cycle
//   ST_DONE  | one-cycle done pulse
module lcd_img_ctrl
    import lcd_img_pkg::*;
#(
    parameter int DW     = 8,
    parameter int W_LOG2 = 3,
    parameter int H_LOG2 = 3,
    localparam int AW    = W_LOG2 + H_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          busy,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    input  logic [DW-1:0] IROM_Q,
    output logic          IRAM_valid,
    output logic [AW-1:0] IRAM_A,
    output logic [DW-1:0] IRAM_D,
    output logic          done
);

    localparam int IMG_W = 2 ** W_LOG2;
    localparam int IMG_H = 2 ** H_LOG2;
    localparam int N     = 2 ** AW;

    localparam logic [W_LOG2-1:0] X_ONE  = W_LOG2'(1);
    localparam logic [W_LOG2-1:0] X_MID  = W_LOG2'(IMG_W / 2);
    localparam logic [W_LOG2-1:0] X_MAX  = W_LOG2'(IMG_W - 1);
    localparam logic [H_LOG2-1:0] Y_ONE  = H_LOG2'(1);
    localparam logic [H_LOG2-1:0] Y_MID  = H_LOG2'(IMG_H / 2);
    localparam logic [H_LOG2-1:0] Y_MAX  = H_LOG2'(IMG_H - 1);
    localparam logic [AW-1:0]     A_ZERO = '0;
    localparam logic [AW-1:0]     A_ONE  = AW'(1);
    localparam logic [AW-1:0]     A_LAST = AW'(N - 1);

    state_t state, state_nxt;

    logic [DW-1:0]     img [N];
    logic [W_LOG2-1:0] org_x, org_xm1;
    logic [H_LOG2-1:0] org_y, org_ym1;
    logic [AW-1:0]     idx0, idx1, idx2, idx3;
    logic [DW-1:0]     p0, p1, p2, p3, q0, q1, q2, q3;
    logic              alu_we;
    logic              ld_drain, ld_cap;
    logic [AW-1:0]     ld_addr;
    logic [3:0]        cmd_q;
    logic              accept;
    logic [AW-1:0]     ram_a_nxt;

    assign accept    = (state == ST_CMD) && cmd_valid;
    assign busy      = (state != ST_CMD);
    assign done      = (state == ST_DONE);
    assign ram_a_nxt = IRAM_A + A_ONE;

    // Origin is the lower-right pixel of the window; index = {y, x}.
    assign org_xm1 = org_x - X_ONE;
    assign org_ym1 = org_y - Y_ONE;
    assign idx0    = {org_ym1, org_xm1};
    assign idx1    = {org_ym1, org_x};
    assign idx2    = {org_y,   org_xm1};
    assign idx3    = {org_y,   org_x};
    assign p0      = img[idx0];
    assign p1      = img[idx1];
    assign p2      = img[idx2];
    assign p3      = img[idx3];

    lcd_win_alu #(.DW(DW)) u_alu (
        .cmd (cmd_q),
        .p0  (p0),
        .p1  (p1),
        .p2  (p2),
        .p3  (p3),
        .q0  (q0),
        .q1  (q1),
        .q2  (q2),
        .q3  (q3),
        .we  (alu_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (ld_drain) state_nxt = ST_CMD;
            ST_CMD:   if (cmd_valid) state_nxt = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
            ST_EXEC:  state_nxt = ST_CMD;
            ST_WRITE: if (IRAM_A == A_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_CMD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // IROM read sequencing; returned data is captured one cycle after each read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IROM_rd  <= 1'b0;
            IROM_A   <= A_ZERO;
            ld_drain <= 1'b0;
            ld_cap   <= 1'b0;
            ld_addr  <= A_ZERO;
        end else begin
            ld_cap  <= IROM_rd;
            ld_addr <= IROM_A;
            if (state == ST_LOAD) begin
                if (IROM_rd) begin
                    if (IROM_A == A_LAST) begin
                        IROM_rd  <= 1'b0;
                        IROM_A   <= A_ZERO;
                        ld_drain <= 1'b1;
                    end else begin
                        IROM_A <= IROM_A + A_ONE;
                    end
                end else if (ld_drain) begin
                    ld_drain <= 1'b0;
                end else begin
                    IROM_rd <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            org_x <= X_MID;
            org_y <= Y_MID;
            cmd_q <= CMD_WRITE;
        end else begin
            if (accept) cmd_q <= cmd;
            if (state == ST_EXEC) begin
                case (cmd_q)
                    CMD_UP:     if (org_y != Y_ONE) org_y <= org_ym1;
                    CMD_DOWN:   if (org_y != Y_MAX) org_y <= org_y + Y_ONE;
                    CMD_LEFT:   if (org_x != X_ONE) org_x <= org_xm1;
                    CMD_RIGHT:  if (org_x != X_MAX) org_x <= org_x + X_ONE;
                    CMD_ORIGIN: begin
                        org_x <= X_MID;
                        org_y <= Y_MID;
                    end
                    default: ;
                endcase
            end
        end
    end

    // IRAM outputs are registered; the first pixel is staged on the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IRAM_valid <= 1'b0;
            IRAM_A     <= A_ZERO;
            IRAM_D     <= '0;
        end else if (accept && (cmd == CMD_WRITE)) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= A_ZERO;
            IRAM_D     <= img[A_ZERO];
        end else if (state == ST_WRITE) begin
            if (IRAM_A == A_LAST) begin
                IRAM_valid <= 1'b0;
            end else begin
                IRAM_A <= ram_a_nxt;
                IRAM_D <= img[ram_a_nxt];
            end
        end
    end

    // Buffer contents are not reset; every pixel is rewritten by LOAD.
    always_ff @(posedge clk) begin
        if (ld_cap) img[ld_addr] <= IROM_Q;
        if ((state == ST_EXEC) && alu_we) begin
            img[idx0] <= q0;
            img[idx1] <= q1;
            img[idx2] <= q2;
            img[idx3] <= q3;
        end
    end

endmodule

// File: tb/tb_lcd_img_ctrl.sv
// Bench for lcd_img_ctrl: two configurations (8b 8x8 and 10b 16x4) run in lockstep on shared
// commands, with an IRAM scoreboard fed from a behavioural image model.
module tb_lcd_img_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;

    logic       busy_a, rd_a, valid_a, done_a;
    logic [5:0] rom_addr_a, ram_addr_a;
    logic [7:0] q_a, d_a;
    logic       busy_b, rd_b, valid_b, done_b;
    logic [5:0] rom_addr_b, ram_addr_b;
    logic [9:0] q_b, d_b;

    int n_tests = 0;
    int n_fail  = 0;
    int mbuf [2][64];
    int seen [2][64];
    int mx [2];
    int my [2];
    int iw [2] = '{8, 16};
    int ih [2] = '{8, 4};
    int qa [$];
    int qb [$];

    always #5 clk = ~clk;

    lcd_img_ctrl #(.DW(8), .W_LOG2(3), .H_LOG2(3)) dut_a (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy_a),
        .IROM_rd(rd_a), .IROM_A(rom_addr_a), .IROM_Q(q_a),
        .IRAM_valid(valid_a), .IRAM_A(ram_addr_a), .IRAM_D(d_a), .done(done_a)
    );

    lcd_img_ctrl #(.DW(10), .W_LOG2(4), .H_LOG2(2)) dut_b (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy_b),
        .IROM_rd(rd_b), .IROM_A(rom_addr_b), .IROM_Q(q_b),
        .IRAM_valid(valid_b), .IRAM_A(ram_addr_b), .IRAM_D(d_b), .done(done_b)
    );

    function automatic int rom_val(input int k, input int a);
        return (k == 0) ? a : (a * 37 + 11) % 1024;
    endfunction

    always @(posedge clk) begin
        q_a <= 8'(rom_val(0, int'(rom_addr_a)));
        q_b <= 10'(rom_val(1, int'(rom_addr_b)));
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_load();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mbuf[k][a] = rom_val(k, a);
            mx[k] = iw[k] / 2;
            my[k] = ih[k] / 2;
        end
    endfunction

    function automatic void model_cmd(input int c);
        int i0, i1, i2, i3, v0, v1, v2, v3, n0, n1, n2, n3, w, h, m;
        for (int k = 0; k < 2; k++) begin
            w  = iw[k];
            h  = ih[k];
            i0 = (my[k] - 1) * w + mx[k] - 1;
            i1 = (my[k] - 1) * w + mx[k];
            i2 = my[k] * w + mx[k] - 1;
            i3 = my[k] * w + mx[k];
            v0 = mbuf[k][i0]; v1 = mbuf[k][i1]; v2 = mbuf[k][i2]; v3 = mbuf[k][i3];
            n0 = v0; n1 = v1; n2 = v2; n3 = v3;
            case (c)
                0: for (int a = 0; a < 64; a++) begin
                       if (k == 0) qa.push_back(a * 4096 + mbuf[0][a]);
                       else        qb.push_back(a * 4096 + mbuf[1][a]);
                   end
                1: if (my[k] > 1) my[k]--;
                2: if (my[k] < h - 1) my[k]++;
                3: if (mx[k] > 1) mx[k]--;
                4: if (mx[k] < w - 1) mx[k]++;
                5: begin
                       m = v0;
                       if (v1 > m) m = v1;
                       if (v2 > m) m = v2;
                       if (v3 > m) m = v3;
                       n0 = m; n1 = m; n2 = m; n3 = m;
                   end
                6: begin
                       m = v0;
                       if (v1 < m) m = v1;
                       if (v2 < m) m = v2;
                       if (v3 < m) m = v3;
                       n0 = m; n1 = m; n2 = m; n3 = m;
                   end
                7: begin
                       m = (v0 + v1 + v2 + v3) / 4;
                       n0 = m; n1 = m; n2 = m; n3 = m;
                   end
                8:  begin n0 = v1; n1 = v3; n2 = v0; n3 = v2; end
                9:  begin n0 = v2; n1 = v0; n2 = v3; n3 = v1; end
                10: begin n0 = v2; n1 = v3; n2 = v0; n3 = v1; end
                11: begin n0 = v1; n1 = v0; n2 = v3; n3 = v2; end
                12: begin mx[k] = w / 2; my[k] = h / 2; end
                default: ;
            endcase
            mbuf[k][i0] = n0; mbuf[k][i1] = n1; mbuf[k][i2] = n2; mbuf[k][i3] = n3;
        end
    endfunction

    always @(negedge clk) begin : mon_a
        int e;
        if (valid_a) begin
            e = -1;
            if (qa.size() > 0) e = qa.pop_front();
            chk_eq("iram_a addr*4096+data", int'(ram_addr_a) * 4096 + int'(d_a), e);
            seen[0][ram_addr_a] = int'(d_a);
        end
    end

    always @(negedge clk) begin : mon_b
        int e;
        if (valid_b) begin
            e = -1;
            if (qb.size() > 0) e = qb.pop_front();
            chk_eq("iram_b addr*4096+data", int'(ram_addr_b) * 4096 + int'(d_b), e);
            seen[1][ram_addr_b] = int'(d_b);
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (busy_a && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk_eq("cmd_ready", int'(busy_a), 0);
    endtask

    task automatic issue(input int c);
        wait_ready();
        cmd       = 4'(c);
        cmd_valid = 1'b1;
        model_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done_a && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk_eq("done_seen", int'(done_a), 1);
    endtask

    task automatic do_write();
        int g = 0;
        int cnt = 0;
        issue(0);
        while (!valid_a && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk_eq("write_start", int'(valid_a), 1);
        while (!done_a && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk_eq("done_latency", cnt, 64);
        chk_eq("done_b_lockstep", int'(done_b), 1);
        @(negedge clk);
        chk_eq("busy_after_done", int'(busy_a), 0);
    endtask

    task automatic load_check();
        int g = 0;
        int cnt = 64;
        while (!rd_a && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk_eq("load_start", int'(rd_a), 1);
        for (int i = 0; i < 64; i++) begin
            chk_eq("irom_rd", int'(rd_a), 1);
            chk_eq("irom_addr", int'(rom_addr_a), i);
            @(negedge clk);
        end
        chk_eq("irom_rd_drain", int'(rd_a), 0);
        while (busy_a && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk_eq("load_cycles", cnt, 65);
        model_load();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_busy", int'(busy_a), 1);
        chk_eq("rst_irom_rd", int'(rd_a), 0);
        chk_eq("rst_irom_a", int'(rom_addr_a), 0);
        chk_eq("rst_iram_valid", int'(valid_a), 0);
        chk_eq("rst_iram_a", int'(ram_addr_a), 0);
        chk_eq("rst_iram_d", int'(d_a), 0);
        chk_eq("rst_done", int'(done_a), 0);
        chk_eq("rst_busy_b", int'(busy_b), 1);
        reset = 1'b1;

        load_check();
        do_write();
        chk_eq("first_write_63", seen[0][63], 63);

        issue(7);
        for (int i = 0; i < 5; i++) issue(3);
        for (int i = 0; i < 5; i++) issue(1);
        issue(5);
        issue(3);
        issue(1);
        issue(4);
        issue(6);
        do_write();
        chk_eq("avg_buf27", seen[0][27], 31);
        chk_eq("max_buf0", seen[0][0], 9);
        chk_eq("max_buf8", seen[0][8], 9);
        chk_eq("sat_min_buf1", seen[0][1], 2);

        // Held strobe through EXEC: accepts only on alternate cycles.
        issue(12);
        wait_ready();
        cmd       = 4'd4;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_eq("hold_busy", int'(busy_a), i % 2);
            if (i % 2 == 0) model_cmd(4);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        issue(11);

        // Held strobe through WRITE: back-to-back identical dumps.
        wait_ready();
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        model_cmd(0);
        model_cmd(0);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        @(negedge clk);
        chk_eq("rewrite_busy", int'(busy_a), 1);
        cmd_valid = 1'b0;
        wait_done();
        @(negedge clk);
        chk_eq("rewrite_q_a", qa.size(), 0);
        chk_eq("rewrite_q_b", qb.size(), 0);

        // Reset in the middle of a dump.
        issue(0);
        begin
            int g = 0;
            while (!(valid_a && ram_addr_a == 6'd20) && g < 200) begin
                @(negedge clk);
                g++;
            end
        end
        chk_eq("abort_at_20", int'(ram_addr_a), 20);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("abort_valid", int'(valid_a), 0);
        chk_eq("abort_valid_b", int'(valid_b), 0);
        chk_eq("abort_busy", int'(busy_a), 1);
        chk_eq("abort_iram_a", int'(ram_addr_a), 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        reset = 1'b1;
        load_check();

        issue(9);
        issue(8);
        issue(10);
        issue(13);
        do_write();
        chk_eq("mirx_buf27", seen[0][27], 35);
        chk_eq("mirx_buf35", seen[0][35], 27);
        chk_eq("mirx_buf28", seen[0][28], 36);
        chk_eq("mirx_buf36", seen[0][36], 28);

        issue(11);
        issue(7);
        do_write();
        chk_eq("avg2_buf27", seen[0][27], 31);
        chk_eq("avg_b_buf23", seen[1][23], 664);
        chk_eq("avg_b_buf40", seen[1][40], 664);

        chk_eq("sb_a_empty", qa.size(), 0);
        chk_eq("sb_b_empty", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
